ksa_shuffle_fsm: RTL

Sequencer for the RC4 key-scheduling shuffle (second KSA phase) over the 256×8 S memory. It starts after the S-initialisation FSM has written S[i]=i. For i = 0..255 it computes j = j + S[i] + key[i mod KEY_LENGTH] and swaps S[i] and S[j] through the single memory port. It sits beside the init FSM and drives the S memory's address/data/wren bus while busy; a later decrypt stage consumes the shuffled S.

---
 rtl/ksa_shuffle_fsm.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ksa_shuffle_fsm.sv
// ----------------------------------------------------------------------------
// ksa_shuffle_fsm
//
// Purpose:
//   Sequencer for the RC4 key-scheduling shuffle over a 256x8 S memory that
//   has already been initialised to S[i] = i. For i = 0..255 it computes
//   j = j + S[i] + key[i mod KEY_LENGTH] and swaps S[i] and S[j] through the
//   single memory port. Each iteration takes exactly 9 cycles.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high
//   start       in   run request, sampled only in IDLE and DONE
//   secret_key  in   8*KEY_LENGTH key, byte 0 is the most significant byte
//   q           in   S memory read data (valid one cycle after the address)
//   address     out  S memory address
//   data        out  S memory write data
//   wren        out  S memory write enable
//   busy        out  high while a shuffle is running
//   done        out  high in DONE until the next start acceptance or reset
//   state_dbg   out  current FSM state encoding
//
// Handshake: start is a level request with no ready. It is accepted on any
// rising edge where the FSM is in IDLE or DONE and start=1; everywhere else
// it is ignored. done is a held status, not a pulse.
// ----------------------------------------------------------------------------
module ksa_shuffle_fsm #(
   parameter int KEY_LENGTH = 3
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [8*KEY_LENGTH-1:0]   secret_key,
   input  logic [7:0]                q,
   output logic [7:0]                address,
   output logic [7:0]                data,
   output logic                      wren,
   output logic                      busy,
   output logic                      done,
   output logic [3:0]                state_dbg
);

   localparam int KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
   localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_LENGTH - 1);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      RD_I    = 4'd1,
      WAIT_I  = 4'd2,
      CALC_J  = 4'd3,
      RD_J    = 4'd4,
      WAIT_J  = 4'd5,
      LATCH_J = 4'd6,
      WR_I    = 4'd7,
      WR_J    = 4'd8,
      NEXT    = 4'd9,
      DONE    = 4'd10
   } state_t;

   state_t                    state;
   state_t                    state_next;
   logic [7:0]                i;
   logic [7:0]                j;
   logic [7:0]                si;
   logic [7:0]                sj;
   logic [8*KEY_LENGTH-1:0]   key_r;
   // Tracks i mod KEY_LENGTH so no divider is needed.
   logic [KIDX_W-1:0]         kidx;
   logic [7:0]                key_byte;

   // Byte 0 sits in the most significant position of the key.
   always_comb begin
      key_byte = 8'h00;
      for (int k = 0; k < KEY_LENGTH; k++) begin
         if (kidx == KIDX_W'(k)) begin
            key_byte = key_r[8*(KEY_LENGTH-1-k) +: 8];
         end
      end
   end

   // State register and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         i     <= 8'h00;
         j     <= 8'h00;
         si    <= 8'h00;
         sj    <= 8'h00;
         key_r <= '0;
         kidx  <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  key_r <= secret_key;
                  i     <= 8'h00;
                  j     <= 8'h00;
                  kidx  <= '0;
               end
            end
            CALC_J: begin
               // q holds S[i] here: the address was presented for two cycles.
               si <= q;
               j  <= j + q + key_byte;
            end
            LATCH_J: begin
               sj <= q;
            end
            NEXT: begin
               if (i != 8'hFF) begin
                  i    <= i + 8'h01;
                  kidx <= (kidx == KIDX_LAST) ? '0 : kidx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and memory-bus decode. When i == j, WR_J lands last with the
   // original S[i], so a self-swap leaves the location unchanged.
   always_comb begin
      state_next = state;
      address    = 8'h00;
      data       = 8'h00;
      wren       = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = RD_I;
         end
         RD_I: begin
            address    = i;
            state_next = WAIT_I;
         end
         WAIT_I: begin
            address    = i;
            state_next = CALC_J;
         end
         CALC_J: begin
            address    = i;
            state_next = RD_J;
         end
         RD_J: begin
            address    = j;
            state_next = WAIT_J;
         end
         WAIT_J: begin
            address    = j;
            state_next = LATCH_J;
         end
         LATCH_J: begin
            address    = j;
            state_next = WR_I;
         end
         WR_I: begin
            address    = i;
            data       = sj;
            wren       = 1'b1;
            state_next = WR_J;
         end
         WR_J: begin
            address    = j;
            data       = si;
            wren       = 1'b1;
            state_next = NEXT;
         end
         NEXT: begin
            state_next = (i == 8'hFF) ? DONE : RD_I;
         end
         DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (start) state_next = RD_I;
         end
         default: begin
            busy       = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   assign state_dbg = state;

endmodule
